// File: rtl/regfile_wr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_scoreboard
// Brief    : Register-file write-port one-hot decoder with a destination
//            scoreboard that flags RAW hazards on two read ports.
// Revision : 1.0
// ============================================================================
module regfile_wr_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int OUT_REG  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic                flush,
  output logic [NUM_REGS-1:0] regOut,
  output logic [NUM_REGS-1:0] busy,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic                err_double_issue
);

  // One extra bit so ZERO_REG == NUM_REGS (masking disabled) never matches.
  localparam logic [ADDR_W:0] ZERO_IDX = (ADDR_W+1)'(ZERO_REG);

  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] wr_vec;
  logic [NUM_REGS-1:0] iss_vec;
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic                err_d, err_q;
  logic                wr_nz, iss_nz, rda_nz, rdb_nz;
  logic                wr_hits_iss;

  always_comb begin
    wr_nz       = {1'b0, wr_addr}    != ZERO_IDX;
    iss_nz      = {1'b0, issue_addr} != ZERO_IDX;
    rda_nz      = {1'b0, rd_addr_a}  != ZERO_IDX;
    rdb_nz      = {1'b0, rd_addr_b}  != ZERO_IDX;
    wr_hits_iss = wr_en && (wr_addr == issue_addr);

    dec     = '0;
    wr_vec  = '0;
    iss_vec = '0;
    if (wr_en)
      wr_vec[wr_addr] = 1'b1;
    if (wr_en && wr_nz)
      dec[wr_addr] = 1'b1;
    if (issue_en && iss_nz)
      iss_vec[issue_addr] = 1'b1;

    // Flush beats everything; a new producer beats a same-cycle writeback.
    if (flush)
      busy_d = '0;
    else
      busy_d = (busy_q & ~wr_vec) | iss_vec;

    err_d = err_q | (issue_en && iss_nz && busy_q[issue_addr] && !wr_hits_iss && !flush);
  end

  always_comb begin
    hazard_a = busy_q[rd_addr_a] && rda_nz && !(wr_en && (wr_addr == rd_addr_a));
    hazard_b = busy_q[rd_addr_b] && rdb_nz && !(wr_en && (wr_addr == rd_addr_b));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy             = busy_q;
  assign err_double_issue = err_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [NUM_REGS-1:0] regout_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          regout_q <= '0;
        else
          regout_q <= dec;
      end
      assign regOut = regout_q;
    end else begin : g_out_comb
      assign regOut = reset ? '0 : dec;
    end
  endgenerate

endmodule
`default_nettype wire
